// File: rtl/fetch_align_buf_pkg.sv
// Shared Y86-64 fetch definitions: register/word widths, opcode encodings
// and the decoded-length record handed from the length decoder to the aligner.
package fetch_align_buf_pkg;

  localparam int REGBUS   = 4;
  localparam int WORD     = 64;
  localparam int MAX_ILEN = 10;

  typedef logic [REGBUS-1:0] reg_t;
  typedef logic [WORD-1:0]   word_t;

  localparam reg_t RNONE = 4'hF;

  typedef enum logic [3:0] {
    IHALT   = 4'h0,
    INOP    = 4'h1,
    IRRMOVQ = 4'h2,
    IIRMOVQ = 4'h3,
    IRMMOVQ = 4'h4,
    IMRMOVQ = 4'h5,
    IOPQ    = 4'h6,
    IJXX    = 4'h7,
    ICALL   = 4'h8,
    IRET    = 4'h9,
    IPUSHQ  = 4'hA,
    IPOPQ   = 4'hB
  } icode_e;

  typedef struct packed {
    logic [3:0] ilen;
    logic       need_regids;
    logic       need_valc;
    logic       inval;
  } len_info_t;

endpackage

// File: rtl/fetch_align_buf_len_decode.sv
// Head-byte opcode to instruction length and field-presence decode.
// Purely combinational so the predecode path can reuse it.
module fa_len_decode
  import fetch_align_buf_pkg::*;
(
  input  logic [3:0] icode_i,
  output len_info_t  info_o
);

  // Opcode class lookup; unknown opcodes are one byte long and flagged.
  always_comb begin
    info_o.ilen        = 4'd1;
    info_o.need_regids = 1'b0;
    info_o.need_valc   = 1'b0;
    info_o.inval       = 1'b0;
    case (icode_e'(icode_i))
      IHALT, INOP, IRET: begin
        info_o.ilen = 4'd1;
      end
      IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: begin
        info_o.ilen        = 4'd2;
        info_o.need_regids = 1'b1;
      end
      IJXX, ICALL: begin
        info_o.ilen      = 4'd9;
        info_o.need_valc = 1'b1;
      end
      IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
        info_o.ilen        = 4'd10;
        info_o.need_regids = 1'b1;
        info_o.need_valc   = 1'b1;
      end
      default: begin
        info_o.ilen  = 4'd1;
        info_o.inval = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/fetch_align_buf.sv
// Buffered Y86-64 fetch aligner: byte queue fed by memory chunks, one aligned
// instruction presented per cycle from the queue head.
module fetch_align_buf
  import fetch_align_buf_pkg::*;
#(
  parameter int                FETCH_BYTES = 8,
  parameter int                BUF_BYTES   = 32,
  parameter int                WORD_W      = 64,
  parameter logic [WORD_W-1:0] RESET_PC    = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [FETCH_BYTES*8-1:0] in_bytes,
  input  logic                     redirect,
  input  logic [WORD_W-1:0]        redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_icode,
  output logic [3:0]               out_ifun,
  output logic [3:0]               out_rA,
  output logic [3:0]               out_rB,
  output logic [WORD_W-1:0]        out_valC,
  output logic [WORD_W-1:0]        out_pc,
  output logic [WORD_W-1:0]        out_valP,
  output logic [3:0]               out_ilen,
  output logic                     out_inval
);

  localparam int CW = $clog2(BUF_BYTES + FETCH_BYTES + 1);
  localparam int BW = BUF_BYTES * 8;

  // Queue invariant: every byte at index >= count_q is zero, so a push can OR in.
  logic [BW-1:0]     buf_q, buf_d;
  logic [CW-1:0]     count_q, count_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic              stopped_q, stopped_d;

  len_info_t         info_s;
  logic              valid_s;
  logic              take_s;
  logic              pop_s;
  logic              push_s;
  logic [CW-1:0]     pop_len_s;
  logic [CW-1:0]     base_s;
  logic [63:0]       valc_s;
  logic [BW-1:0]     shifted_s;
  logic [BW-1:0]     push_word_s;

  fa_len_decode u_len_decode (
    .icode_i (buf_q[7:4]),
    .info_o  (info_s)
  );

  assign valid_s     = !stopped_q && (count_q != '0) && (count_q >= CW'(info_s.ilen));
  assign take_s      = valid_s && out_ready;
  assign pop_s       = take_s && !redirect;
  assign pop_len_s   = take_s ? CW'(info_s.ilen) : '0;
  assign base_s      = count_q - pop_len_s;
  assign in_ready    = !redirect && ((base_s + CW'(FETCH_BYTES)) <= CW'(BUF_BYTES));
  assign push_s      = in_valid && in_ready;
  assign shifted_s   = buf_q >> {pop_len_s, 3'b000};
  assign push_word_s = {{(BW - FETCH_BYTES * 8){1'b0}}, in_bytes} << {base_s, 3'b000};

  // Constant field sits after the register byte when one is present.
  always_comb begin
    valc_s = 64'd0;
    if (info_s.need_valc) begin
      if (info_s.need_regids) begin
        valc_s = buf_q[79:16];
      end else begin
        valc_s = buf_q[71:8];
      end
    end else begin
      valc_s = 64'd0;
    end
  end

  // Next queue/pc/stop state; redirect overrides any same-cycle pop or push.
  always_comb begin
    buf_d     = buf_q;
    count_d   = count_q;
    pc_d      = pc_q;
    stopped_d = stopped_q;
    if (redirect) begin
      buf_d     = '0;
      count_d   = '0;
      pc_d      = redirect_pc;
      stopped_d = 1'b0;
    end else begin
      if (push_s) begin
        buf_d   = shifted_s | push_word_s;
        count_d = base_s + CW'(FETCH_BYTES);
      end else begin
        buf_d   = shifted_s;
        count_d = base_s;
      end
      if (pop_s) begin
        pc_d = pc_q + WORD_W'(info_s.ilen);
        if ((buf_q[7:4] == 4'h0) || info_s.inval) begin
          stopped_d = 1'b1;
        end else begin
          stopped_d = stopped_q;
        end
      end else begin
        pc_d = pc_q;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q     <= '0;
      count_q   <= '0;
      pc_q      <= RESET_PC;
      stopped_q <= 1'b0;
    end else begin
      buf_q     <= buf_d;
      count_q   <= count_d;
      pc_q      <= pc_d;
      stopped_q <= stopped_d;
    end
  end

  // Decoded fields are forced to zero while nothing is presented, keeping them stable.
  always_comb begin
    out_valid = valid_s;
    out_pc    = pc_q;
    out_icode = 4'h0;
    out_ifun  = 4'h0;
    out_rA    = 4'h0;
    out_rB    = 4'h0;
    out_valC  = '0;
    out_valP  = '0;
    out_ilen  = 4'h0;
    out_inval = 1'b0;
    if (valid_s) begin
      out_icode = buf_q[7:4];
      out_ifun  = buf_q[3:0];
      out_rA    = info_s.need_regids ? buf_q[15:12] : RNONE;
      out_rB    = info_s.need_regids ? buf_q[11:8]  : RNONE;
      out_valC  = WORD_W'(valc_s);
      out_valP  = pc_q + WORD_W'(info_s.ilen);
      out_ilen  = info_s.ilen;
      out_inval = info_s.inval;
    end else begin
      out_icode = 4'h0;
    end
  end

endmodule

// File: tb/tb_fetch_align_buf.sv
// Directed bench for fetch_align_buf with hand-computed expectations.
module tb_fetch_align_buf;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_bytes;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_icode;
  logic [3:0]  out_ifun;
  logic [3:0]  out_rA;
  logic [3:0]  out_rB;
  logic [63:0] out_valC;
  logic [63:0] out_pc;
  logic [63:0] out_valP;
  logic [3:0]  out_ilen;
  logic        out_inval;

  int n_cmp;
  int n_err;

  fetch_align_buf #(
    .FETCH_BYTES (8),
    .BUF_BYTES   (32),
    .WORD_W      (64),
    .RESET_PC    (64'd0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_bytes    (in_bytes),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_icode   (out_icode),
    .out_ifun    (out_ifun),
    .out_rA      (out_rA),
    .out_rB      (out_rB),
    .out_valC    (out_valC),
    .out_pc      (out_pc),
    .out_valP    (out_valP),
    .out_ilen    (out_ilen),
    .out_inval   (out_inval)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [63:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    #1;
    check_val("redir_in_ready", 64'(in_ready), 64'd0);
    step();
    redirect = 1'b0;
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_bytes    = 64'd0;
    redirect    = 1'b0;
    redirect_pc = 64'd0;
    out_ready   = 1'b0;
    #13;
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_in_ready",  64'(in_ready),  64'd1);
    check_val("rst_icode",     64'(out_icode), 64'd0);
    check_val("rst_pc",        out_pc,         64'd0);
    check_val("rst_valP",      out_valP,       64'd0);
    check_val("rst_valC",      out_valC,       64'd0);
    #10;
    rst = 1'b0;
    step();

    // nop then halt
    in_valid = 1'b1;
    in_bytes = 64'h0000_0000_0000_0010;
    #1;
    check_val("empty_valid", 64'(out_valid), 64'd0);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check_val("nop_valid", 64'(out_valid), 64'd1);
    check_val("nop_icode", 64'(out_icode), 64'd1);
    check_val("nop_pc",    out_pc,         64'd0);
    check_val("nop_valP",  out_valP,       64'd1);
    check_val("nop_rA",    64'(out_rA),    64'hF);
    check_val("nop_valC",  out_valC,       64'd0);
    step();
    check_val("halt_valid", 64'(out_valid), 64'd1);
    check_val("halt_icode", 64'(out_icode), 64'd0);
    check_val("halt_pc",    out_pc,         64'd1);
    check_val("halt_valP",  out_valP,       64'd2);
    step();
    check_val("stop_valid", 64'(out_valid), 64'd0);
    check_val("stop_pc",    out_pc,         64'd2);
    out_ready = 1'b0;
    do_redirect(64'd0);

    // irmovq split across two chunks
    in_valid = 1'b1;
    in_bytes = 64'h4567_89AB_CDEF_F330;
    step();
    in_valid = 1'b0;
    #1;
    check_val("irm_partial", 64'(out_valid), 64'd0);
    in_valid = 1'b1;
    in_bytes = 64'h0000_0000_0000_0123;
    step();
    in_valid = 1'b0;
    #1;
    check_val("irm_valid", 64'(out_valid), 64'd1);
    check_val("irm_icode", 64'(out_icode), 64'd3);
    check_val("irm_rA",    64'(out_rA),    64'hF);
    check_val("irm_rB",    64'(out_rB),    64'd3);
    check_val("irm_valC",  out_valC,       64'h0123_4567_89AB_CDEF);
    check_val("irm_ilen",  64'(out_ilen),  64'd10);
    check_val("irm_valP",  out_valP,       64'd10);
    do_redirect(64'd0);

    // jXX with valC at byte 1
    in_valid = 1'b1;
    in_bytes = 64'h0203_0405_0607_0870;
    step();
    in_valid = 1'b0;
    #1;
    check_val("jxx_partial", 64'(out_valid), 64'd0);
    in_valid = 1'b1;
    in_bytes = 64'h0000_0000_0000_0001;
    step();
    in_valid = 1'b0;
    #1;
    check_val("jxx_valid", 64'(out_valid), 64'd1);
    check_val("jxx_icode", 64'(out_icode), 64'd7);
    check_val("jxx_rA",    64'(out_rA),    64'hF);
    check_val("jxx_rB",    64'(out_rB),    64'hF);
    check_val("jxx_valC",  out_valC,       64'h0102_0304_0506_0708);
    check_val("jxx_ilen",  64'(out_ilen),  64'd9);
    check_val("jxx_valP",  out_valP,       64'd9);
    do_redirect(64'd0);

    // Fill with rrmovq %rcx,%rdx and exercise the full-queue boundary
    in_valid = 1'b1;
    in_bytes = 64'h1220_1220_1220_1220;
    for (int i = 0; i < 4; i++) step();
    check_val("full_in_ready", 64'(in_ready),  64'd0);
    check_val("full_icode",    64'(out_icode), 64'd2);
    check_val("full_rA",       64'(out_rA),    64'd1);
    check_val("full_rB",       64'(out_rB),    64'd2);
    check_val("full_ilen",     64'(out_ilen),  64'd2);
    out_ready = 1'b1;
    #1;
    check_val("pop2_no_reopen", 64'(in_ready), 64'd0);
    step();
    out_ready = 1'b0;
    #1;
    check_val("cnt30_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    step();
    step();
    check_val("cnt26_pop_reopen", 64'(in_ready), 64'd1);
    step();
    out_ready = 1'b0;
    #1;
    check_val("refull_in_ready", 64'(in_ready), 64'd0);
    check_val("refull_pc",       out_pc,        64'd8);

    // Redirect while busy: chunk dropped, pc reloaded
    out_ready = 1'b1;
    do_redirect(64'h100);
    in_bytes = 64'h0000_0000_0000_0010;
    #1;
    check_val("redir_valid", 64'(out_valid), 64'd0);
    check_val("redir_pc",    out_pc,         64'h100);
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    #1;
    check_val("redir_nop_valid", 64'(out_valid), 64'd1);
    check_val("redir_nop_icode", 64'(out_icode), 64'd1);
    check_val("redir_nop_pc",    out_pc,         64'h100);

    // Invalid opcode stops fetch after its pop
    do_redirect(64'h200);
    in_valid = 1'b1;
    in_bytes = 64'h0000_0000_0000_10C0;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check_val("inv_valid", 64'(out_valid), 64'd1);
    check_val("inv_flag",  64'(out_inval), 64'd1);
    check_val("inv_icode", 64'(out_icode), 64'hC);
    check_val("inv_ilen",  64'(out_ilen),  64'd1);
    check_val("inv_valP",  out_valP,       64'h201);
    step();
    check_val("inv_stopped", 64'(out_valid), 64'd0);
    check_val("inv_pc",      out_pc,         64'h201);
    out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_align_buf.md
Name: fetch_align_buf

Overview:
- Buffered, parametrised Y86-64 fetch aligner for the pipelined core.
- Accepts fixed-width byte chunks from instruction memory into a byte queue.
- Decodes instruction length from the head byte and presents one aligned instruction per cycle (icode, ifun, rA, rB, valC, pc, valP) on a valid/ready handshake.
- Supports redirect (flush and new PC) and stops after halt or an invalid opcode.

Parameters:
- FETCH_BYTES, 8, bytes delivered per input chunk.
- BUF_BYTES, 32, queue capacity in bytes; must be >= FETCH_BYTES + 10.
- WORD_W, 64, width of valC, pc and valP.
- RESET_PC, 0, PC loaded at reset.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  chunk present.
- in_ready  out  1  chunk accepted when in_valid && in_ready.
- in_bytes  in  FETCH_BYTES*8  memory-order bytes; byte 0 in bits [7:0].
- redirect  in  1  flush queue, restart at redirect_pc.
- redirect_pc  in  WORD_W  new fetch PC.
- out_valid  out  1  aligned instruction available.
- out_ready  in  1  consumer takes the instruction.
- out_icode  out  4  head byte [7:4].
- out_ifun  out  4  head byte [3:0].
- out_rA  out  4  rA, or RNONE (4'hF) when no register byte.
- out_rB  out  4  rB, or RNONE.
- out_valC  out  WORD_W  little-endian constant, or 0.
- out_pc  out  WORD_W  PC of this instruction.
- out_valP  out  WORD_W  out_pc + length.
- out_ilen  out  4  length in bytes.
- out_inval  out  1  icode > 0xB.

Behaviour:
- Reset (async): count=0, pc=RESET_PC, stopped=0; out_valid=0; in_ready=1; all data outputs 0.
- Length table:
  - icode 0, 1, 9 -> 1 byte.
  - icode 2, 6, A, B -> 2 bytes (register byte).
  - icode 7, 8 -> 9 bytes (valC at byte 1).
  - icode 3, 4, 5 -> 10 bytes (register byte, valC at byte 2).
  - Invalid icode -> 1 byte, out_inval=1.
- Head decode is combinational from the registered queue.
- out_valid = !stopped && count >= 1 && count >= len(head).
  - A chunk that completes an instruction in cycle N gives out_valid=1 in cycle N+1.
- valC assembly: byte k of the field maps to bits [8k+7:8k] (little-endian). No byte swap.
  - rA/rB = RNONE and valC = 0 when the instruction has no such field.
- Pop: on out_valid && out_ready, the queue shifts down by len and pc <= pc + len (mod 2^WORD_W).
  - If the popped icode is 0 (halt) or out_inval=1, set stopped=1.
- Push: in_ready = (count - popped_len_this_cycle + FETCH_BYTES <= BUF_BYTES), evaluated after the same-cycle pop.
  - The chunk is appended at index count - popped_len.
- Simultaneous pop and push in one cycle are legal; count updates by +FETCH_BYTES - len.
- Full queue: in_ready=0 unless the same-cycle pop frees enough space.
- Empty or partial instruction: out_valid=0; output data is don't-care but must be stable.
- Redirect has highest priority.
  - Next cycle: count=0, pc=redirect_pc, stopped=0.
  - Any same-cycle pop or push is discarded: the consumer must not treat a same-cycle handshake as taken.
  - in_ready is held 0 during redirect.
- Stopped: out_valid=0; the queue keeps filling until full; only redirect or reset clears it.
- Reset mid-operation: immediate return to the reset values, queue contents lost.

Decomposition:
- Shared defines include: REGBUS, WORD, RNONE, icode constants (IHALT..IPOPQ), and the max instruction length of 10.
- Sub-module fa_len_decode: combinational head-byte-to-length, need-regids and need-valC decode, reusable by the predecode logic.
- Queue storage and shift logic stay in the top module.

Test Plan:
- Reset, then chunk 10 00 then zero padding -> cycle 1: nop, pc=0, valP=1; next: halt, pc=1, valP=2; then stopped, out_valid=0.
- Chunks 30 F3 EF CD AB 89 67 45 | 23 01 .. -> after the second chunk: icode=3, rA=F, rB=3, valC=0x0123456789ABCDEF, valP=10; out_valid=0 after the first chunk alone.
- Chunk 70 08 07 06 05 04 03 02 | 01 .. -> icode=7, rA=rB=F, valC=0x0102030405060708, ilen=9.
- out_ready=0 with in_valid=1 held -> count saturates at BUF_BYTES; in_ready=0 while full; a one-cycle out_ready with a 2-byte instruction does not reopen in_ready; in_ready rises once FETCH_BYTES are free.
- redirect=1 with redirect_pc=0x100 while the queue is half full and in_valid=1 -> next cycle count=0, out_pc=0x100, chunk dropped, stopped cleared.
- Head byte C0 -> out_inval=1, ilen=1, valP=pc+1; after the pop, stopped=1.
